// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: holds PC and IF/ID with an ID/EX bubble on load-use, branch-in-ID and mul/div hazards.
module hazard_stall_unit #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_RegRs,
    input  logic [4:0]       IFID_RegRt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_IsBranch,
    input  logic             IFID_IsMulDiv,
    input  logic             IFID_IsMfHiLo,
    input  logic             IFID_Kill,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_RegRd,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_RegRd,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             MulDiv_Busy,
    output logic [CNT_W-1:0] Stall_Count
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use, br_ex, br_mem, md_haz, stall, launch;

    // A producer writing $0 never creates a dependency.
    function automatic logic src_match(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic uses_rt, input logic [4:0] x);
        return (x != 5'd0) && ((rs == x) || (uses_rt && (rt == x)));
    endfunction

    always_comb begin
        load_use = IDEX_MemRead && src_match(IFID_RegRs, IFID_RegRt, IFID_UsesRt, IDEX_RegRd);
        br_ex    = IFID_IsBranch && IDEX_RegWrite && src_match(IFID_RegRs, IFID_RegRt, IFID_UsesRt, IDEX_RegRd);
        br_mem   = IFID_IsBranch && EXMEM_MemRead && src_match(IFID_RegRs, IFID_RegRt, IFID_UsesRt, EXMEM_RegRd);
        md_haz   = (state_q == BUSY) && (IFID_IsMulDiv || IFID_IsMfHiLo);
        stall    = !IFID_Kill && (load_use || br_ex || br_mem || md_haz);
        launch   = IFID_IsMulDiv && !stall && !IFID_Kill;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (state_q == IDLE) begin
            state_d = launch ? BUSY : IDLE;
            cnt_d   = launch ? MULDIV_LAT[7:0] : 8'd0;
        end else begin
            state_d = (cnt_q == 8'd1) ? IDLE : BUSY;
            cnt_d   = (cnt_q == 8'd1) ? 8'd0 : cnt_q - 8'd1;
        end
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // Reset holds the front end and pushes bubbles regardless of hazards.
    always_comb begin
        MulDiv_Busy = rst_n && (state_q == BUSY);
        PC_Write    = rst_n && !stall;
        IFID_Write  = rst_n && !stall;
        IDEX_Bubble = !rst_n || stall || IFID_Kill;
        Stall_Count = stall_cnt_q;
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors with hand-computed expectations for hazard_stall_unit.
module tb_hazard_stall_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IFID_RegRs, IFID_RegRt, IDEX_RegRd, EXMEM_RegRd;
    logic       IFID_UsesRt, IFID_IsBranch, IFID_IsMulDiv, IFID_IsMfHiLo, IFID_Kill;
    logic       IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
    logic       PC_Write, IFID_Write, IDEX_Bubble, MulDiv_Busy;
    logic [3:0] Stall_Count;
    int         checks = 0;
    int         errors = 0;

    hazard_stall_unit #(.MULDIV_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_IsBranch(IFID_IsBranch), .IFID_IsMulDiv(IFID_IsMulDiv), .IFID_IsMfHiLo(IFID_IsMfHiLo),
        .IFID_Kill(IFID_Kill), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_RegRd(IDEX_RegRd), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegRd(EXMEM_RegRd),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
        .MulDiv_Busy(MulDiv_Busy), .Stall_Count(Stall_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {IFID_RegRs, IFID_RegRt, IDEX_RegRd, EXMEM_RegRd} = '0;
        {IFID_UsesRt, IFID_IsBranch, IFID_IsMulDiv, IFID_IsMfHiLo, IFID_Kill} = '0;
        {IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead} = '0;
    endtask

    // {PC_Write, IFID_Write, IDEX_Bubble}
    task automatic hold(input string tag, input logic [2:0] exp);
        #1 check(tag, {PC_Write, IFID_Write, IDEX_Bubble}, exp);
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        #1 hold("rst_ctl", 3'b001);
        check("rst_busy", MulDiv_Busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        hold("idle_ctl", 3'b110);
        check("idle_cnt", Stall_Count, 0);
        check("idle_busy", MulDiv_Busy, 0);

        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_RegRd = 8; IFID_RegRs = 8;
        hold("lu_stall", 3'b001);
        tick();
        check("lu_cnt", Stall_Count, 1);
        clr(); IFID_RegRs = 8;
        hold("lu_after", 3'b110);

        IDEX_MemRead = 1; IDEX_RegRd = 0; IFID_RegRs = 0;
        hold("lu_r0", 3'b110);
        IDEX_RegRd = 9; IFID_RegRs = 1; IFID_RegRt = 9; IFID_UsesRt = 0;
        hold("lu_rt_unused", 3'b110);
        IFID_UsesRt = 1;
        hold("lu_rt_used", 3'b001);
        clr(); tick();
        check("r0_cnt", Stall_Count, 1);

        IDEX_RegWrite = 1; IDEX_RegRd = 5; IFID_IsBranch = 1; IFID_RegRs = 5;
        hold("br_ex", 3'b001);
        IFID_IsBranch = 0;
        hold("alu_nobr", 3'b110);
        IFID_IsBranch = 1;
        tick();
        IDEX_RegWrite = 0; IDEX_RegRd = 0;
        hold("br_ex_done", 3'b110);
        check("br_ex_cnt", Stall_Count, 2);

        clr();
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_RegRd = 6;
        IFID_IsBranch = 1; IFID_RegRt = 6; IFID_UsesRt = 1; IFID_RegRs = 2;
        hold("br_ld1", 3'b001);
        tick();
        check("br_ld1_cnt", Stall_Count, 3);
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_RegRd = 0;
        EXMEM_MemRead = 1; EXMEM_RegRd = 6;
        hold("br_mem", 3'b001);
        IFID_IsBranch = 0;
        hold("mem_nobr", 3'b110);
        IFID_IsBranch = 1;
        tick();
        check("br_mem_cnt", Stall_Count, 4);
        EXMEM_MemRead = 0; EXMEM_RegRd = 0;
        hold("br_mem_done", 3'b110);
        clr();

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst2_cnt", Stall_Count, 0);
        IFID_IsMulDiv = 1;
        hold("md_launch", 3'b110);
        tick();
        IFID_IsMulDiv = 0; IFID_IsMfHiLo = 1;
        for (int i = 0; i < 4; i++) begin
            hold($sformatf("mfhi_stall%0d", i), 3'b001);
            check($sformatf("md_busy%0d", i), MulDiv_Busy, 1);
            tick();
        end
        hold("mfhi_go", 3'b110);
        check("md_idle", MulDiv_Busy, 0);
        check("md_cnt", Stall_Count, 4);

        IFID_IsMfHiLo = 0; IFID_IsMulDiv = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            hold($sformatf("mult2_stall%0d", i), 3'b001);
            check($sformatf("md2_busy%0d", i), MulDiv_Busy, 1);
            tick();
        end
        hold("mult2_go", 3'b110);
        check("md2_idle", MulDiv_Busy, 0);
        check("md2_cnt", Stall_Count, 8);
        tick();
        check("md2_relaunch", MulDiv_Busy, 1);

        clr();
        rst_n = 1'b0;
        hold("rst_mid_ctl", 3'b001);
        check("rst_mid_busy", MulDiv_Busy, 0);
        tick();
        rst_n = 1'b1;
        #1 check("rst_mid_busy2", MulDiv_Busy, 0);
        check("rst_mid_cnt", Stall_Count, 0);
        tick();
        check("rst_mid_stay", MulDiv_Busy, 0);

        IFID_Kill = 1; IDEX_MemRead = 1; IDEX_RegRd = 8; IFID_RegRs = 8; IFID_IsMulDiv = 1;
        hold("kill_ctl", 3'b111);
        tick();
        check("kill_busy", MulDiv_Busy, 0);
        check("kill_cnt", Stall_Count, 0);
        IFID_Kill = 0; IFID_IsMulDiv = 0;

        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat_14", Stall_Count, 14);
        end
        check("sat_15", Stall_Count, 15);
        hold("sat_ctl", 3'b001);
        clr();
        tick();
        check("sat_hold", Stall_Count, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
